// File: rtl/sc_match_scorer.sv
// Grades serialized hit events and note misses, tracks combo/multiplier, accumulates song score.
// Latency: grade at edge 1, pulses/combo/multiplier after edge 2, score after edge 3; 1 event/cycle.
// No backpressure: match_en and miss_en are accepted every cycle.
module sc_match_scorer #(
  parameter int unsigned PERFECT_WIN = 2,
  parameter int unsigned GOOD_WIN    = 5,
  parameter int unsigned PERFECT_PTS = 50,
  parameter int unsigned GOOD_PTS    = 25,
  parameter int unsigned COMBO_STEP  = 10,
  parameter int unsigned MAX_MULT    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        match_en,
  input  logic [15:0] match_dt,
  input  logic        miss_en,
  output logic        hit_perfect,
  output logic        hit_good,
  output logic        hit_miss,
  output logic [9:0]  combo,
  output logic [9:0]  max_combo,
  output logic [2:0]  multiplier,
  output logic [23:0] score
);

  localparam logic [1:0] GR_PERFECT = 2'd0;
  localparam logic [1:0] GR_GOOD    = 2'd1;
  localparam logic [1:0] GR_LATE    = 2'd2;

  localparam int unsigned SW = (COMBO_STEP > 1) ? $clog2(COMBO_STEP) : 1;

  // stage 1: magnitude and grade
  logic [15:0] dt_neg;
  logic [15:0] dt_abs;
  logic [1:0]  grade_next;

  always_comb begin
    dt_neg = ~match_dt + 16'd1;
    dt_abs = match_dt[15] ? dt_neg : match_dt;
    // only -32768 still has the top bit set after negation
    if (dt_abs[15]) dt_abs = 16'h7FFF;
    if (dt_abs <= 16'(PERFECT_WIN))   grade_next = GR_PERFECT;
    else if (dt_abs <= 16'(GOOD_WIN)) grade_next = GR_GOOD;
    else                              grade_next = GR_LATE;
  end

  logic       s1_vld;
  logic [1:0] s1_grade;
  logic       s1_miss;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld   <= 1'b0;
      s1_grade <= GR_PERFECT;
      s1_miss  <= 1'b0;
    end else if (clear) begin
      s1_vld   <= 1'b0;
      s1_grade <= GR_PERFECT;
      s1_miss  <= 1'b0;
    end else begin
      s1_vld   <= match_en;
      s1_grade <= match_en ? grade_next : GR_PERFECT;
      s1_miss  <= miss_en;
    end
  end

  // stage 2: combo, step counter, multiplier, points
  logic [SW-1:0] step;
  logic [SW-1:0] step_inc;
  logic          step_wrap;
  logic          hit_ok;
  logic          late;
  logic [9:0]    combo_inc;
  logic [2:0]    mult_inc;
  logic [11:0]   base_pts;
  logic [11:0]   pts_next;

  always_comb begin
    hit_ok    = s1_vld && (s1_grade != GR_LATE);
    late      = s1_vld && (s1_grade == GR_LATE);
    combo_inc = (combo == 10'h3FF) ? combo : combo + 10'd1;
    step_wrap = (step == SW'(COMBO_STEP - 1));
    step_inc  = step_wrap ? '0 : step + SW'(1);
    mult_inc  = (step_wrap && (multiplier < 3'(MAX_MULT))) ? multiplier + 3'd1 : multiplier;
    base_pts  = (s1_grade == GR_PERFECT) ? 12'(PERFECT_PTS) : 12'(GOOD_PTS);
    pts_next  = hit_ok ? base_pts * {9'd0, mult_inc} : 12'd0;
  end

  logic        pts_vld;
  logic [11:0] pts;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      combo       <= 10'd0;
      max_combo   <= 10'd0;
      multiplier  <= 3'd1;
      step        <= '0;
      hit_perfect <= 1'b0;
      hit_good    <= 1'b0;
      hit_miss    <= 1'b0;
      pts_vld     <= 1'b0;
      pts         <= 12'd0;
    end else if (clear) begin
      combo       <= 10'd0;
      max_combo   <= 10'd0;
      multiplier  <= 3'd1;
      step        <= '0;
      hit_perfect <= 1'b0;
      hit_good    <= 1'b0;
      hit_miss    <= 1'b0;
      pts_vld     <= 1'b0;
      pts         <= 12'd0;
    end else begin
      hit_perfect <= hit_ok && (s1_grade == GR_PERFECT);
      hit_good    <= hit_ok && (s1_grade == GR_GOOD);
      hit_miss    <= late || s1_miss;
      pts_vld     <= hit_ok;
      pts         <= pts_next;
      if (hit_ok && (combo_inc > max_combo)) max_combo <= combo_inc;
      // a hit coinciding with miss_en is scored first, then the chain breaks
      if (late || s1_miss) begin
        combo      <= 10'd0;
        step       <= '0;
        multiplier <= 3'd1;
      end else if (hit_ok) begin
        combo      <= combo_inc;
        step       <= step_inc;
        multiplier <= mult_inc;
      end
    end
  end

  // stage 3: saturating score accumulate
  logic [24:0] score_sum;

  always_comb score_sum = {1'b0, score} + {13'd0, pts};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score <= 24'd0;
    end else if (clear) begin
      score <= 24'd0;
    end else if (pts_vld) begin
      score <= score_sum[24] ? 24'hFFFFFF : score_sum[23:0];
    end
  end

endmodule

// File: tb/tb_sc_match_scorer.sv
// Directed bench for sc_match_scorer with hand-computed expectations.
module tb_sc_match_scorer;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic        match_en;
  logic [15:0] match_dt;
  logic        miss_en;
  logic        hit_perfect;
  logic        hit_good;
  logic        hit_miss;
  logic [9:0]  combo;
  logic [9:0]  max_combo;
  logic [2:0]  multiplier;
  logic [23:0] score;

  int checks = 0;
  int errors = 0;

  sc_match_scorer dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .match_en   (match_en),
    .match_dt   (match_dt),
    .miss_en    (miss_en),
    .hit_perfect(hit_perfect),
    .hit_good   (hit_good),
    .hit_miss   (hit_miss),
    .combo      (combo),
    .max_combo  (max_combo),
    .multiplier (multiplier),
    .score      (score)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_perfect"}, 32'(hit_perfect), 0);
    check({tag, "_good"},    32'(hit_good), 0);
    check({tag, "_miss"},    32'(hit_miss), 0);
    check({tag, "_combo"},   32'(combo), 0);
    check({tag, "_max"},     32'(max_combo), 0);
    check({tag, "_mult"},    32'(multiplier), 1);
    check({tag, "_score"},   32'(score), 0);
  endtask

  // one isolated event: pulses/combo checked after two edges, score after three
  task automatic do_event(input string tag, input logic m, input logic [15:0] dt, input logic ms,
                          input logic ep, input logic eg, input logic em,
                          input int ec, input int emult, input int emax, input int esc);
    @(negedge clk);
    match_en = m; match_dt = dt; miss_en = ms;
    @(negedge clk);
    match_en = 1'b0; miss_en = 1'b0; match_dt = 16'h5A5A;
    @(negedge clk);
    check({tag, "_perfect"}, 32'(hit_perfect), 32'(ep));
    check({tag, "_good"},    32'(hit_good), 32'(eg));
    check({tag, "_miss"},    32'(hit_miss), 32'(em));
    check({tag, "_combo"},   32'(combo), 32'(ec));
    check({tag, "_mult"},    32'(multiplier), 32'(emult));
    check({tag, "_max"},     32'(max_combo), 32'(emax));
    @(negedge clk);
    check({tag, "_score"},   32'(score), 32'(esc));
    check({tag, "_pulse_off"}, 32'({hit_perfect, hit_good, hit_miss}), 0);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; match_en = 1'b0; match_dt = 16'd0; miss_en = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    reset = 1'b0;
    @(negedge clk);
    check_idle("post_reset");

    // reset while a hit sits in stage 1
    match_en = 1'b1; match_dt = 16'd0;
    @(negedge clk);
    match_en = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset_inflight");

    do_event("dt_p1",  1'b1, 16'h0001, 1'b0, 1, 0, 0, 1, 1, 1, 50);
    do_event("dt_m4",  1'b1, 16'hFFFC, 1'b0, 0, 1, 0, 2, 1, 2, 75);
    do_event("dt_p7",  1'b1, 16'h0007, 1'b0, 0, 0, 1, 0, 1, 2, 75);
    do_event("dt_m2",  1'b1, 16'hFFFE, 1'b0, 1, 0, 0, 1, 1, 2, 125);
    do_event("miss",   1'b0, 16'h0000, 1'b1, 0, 0, 1, 0, 1, 2, 125);
    do_event("late_miss", 1'b1, 16'h0064, 1'b1, 0, 0, 1, 0, 1, 2, 125);

    // 35 back-to-back perfect hits from a cleared state
    pulse_clear();
    check_idle("clear1");
    for (int i = 0; i < 37; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        check($sformatf("burst_combo_%0d", i - 1), 32'(combo), 32'(i - 1));
        check($sformatf("burst_mult_%0d", i - 1), 32'(multiplier),
              32'(((1 + (i - 1) / 10) > 4) ? 4 : (1 + (i - 1) / 10)));
        check($sformatf("burst_perfect_%0d", i - 1), 32'(hit_perfect), 1);
      end
      match_en = (i < 35); match_dt = 16'd0;
    end
    @(negedge clk);
    check("burst_combo", 32'(combo), 35);
    check("burst_max",   32'(max_combo), 35);
    check("burst_mult",  32'(multiplier), 4);
    check("burst_score", 32'(score), 4150);

    // combo 9 then a perfect hit together with miss_en
    pulse_clear();
    for (int i = 0; i < 9; i++)
      do_event("build", 1'b1, 16'h0000, 1'b0, 1, 0, 0, i + 1, 1, i + 1, 50 * (i + 1));
    do_event("hit_and_miss", 1'b1, 16'h0000, 1'b1, 1, 0, 1, 0, 1, 10, 550);

    do_event("dt_min", 1'b1, 16'h8000, 1'b0, 0, 0, 1, 0, 1, 10, 550);
    do_event("dt_3",   1'b1, 16'h0003, 1'b0, 0, 1, 0, 1, 1, 10, 575);

    // clear in the same cycle as a hit drops it
    @(negedge clk);
    clear = 1'b1; match_en = 1'b1; match_dt = 16'd0;
    @(negedge clk);
    clear = 1'b0; match_en = 1'b0;
    check_idle("clear_now");
    repeat (3) @(negedge clk);
    check_idle("clear_later");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
